pipe_stage_latch: RTL
=====================

// Module: pipe_stage_latch
// PURPOSE
//   Parametrised inter-stage pipeline register for the processor (X/M, M/W and later stages).
//   Carries LANES words of WIDTH bits (lane 0 = instruction, lanes 1.. = operands/results).
//   Adds a valid/ready handshake, an optional 2-entry skid buffer and a synchronous flush
//   that converts held instructions into bubbles.
// PARAMETERS
//   WIDTH   32            bits per lane
//   LANES   3             number of lanes (lane 0 is the instruction lane)
//   SKID    1             1 = 2-entry skid buffer (registered in_ready); 0 = single entry
//   NOP_IR  32'h0000_0000 lane-0 bubble value; must fit in WIDTH bits; other lanes bubble to 0
// PORTS
//   clk        in   1            rising-edge clock
//   reset      in   1            asynchronous, active-low (0 = reset asserted)
//   flush      in   1            synchronous squash of all held entries
//   in_valid   in   1            upstream presents a word set
//   in_ready   out  1            stage accepts; transfer when in_valid & in_ready
//   in_data    in   LANES*WIDTH  lane k at [k*WIDTH +: WIDTH]
//   out_valid  out  1            out_data holds a live entry
//   out_ready  in   1            downstream consumes; transfer when out_valid & out_ready
//   out_data   out  LANES*WIDTH  head entry (bubble pattern when out_valid = 0)
// BEHAVIOUR
//   Reset (async, reset = 0): occupancy EMPTY; main and skid regs = bubble; out_valid = 0;
//     out_data = bubble; in_ready = 1 (both modes) from the first edge after reset releases.
//   Mid-operation reset discards all entries immediately, without waiting for a clock edge.
//   Latency: accepted word appears on out_data one cycle after the accepting edge.
//   Priority per edge: reset > flush > handshake.
//   flush = 1: next state EMPTY; main/skid <= bubble; any same-cycle input transfer and
//     output transfer are dropped (no word is counted as consumed or accepted).
//   SKID = 1: states EMPTY / ONE / TWO; out_valid = (state != EMPTY); in_ready = (state != TWO).
//     in_ready depends only on state (no combinational path from out_ready).
//     EMPTY: in_valid -> main <= in_data, ONE; else stay EMPTY.
//     ONE:  in_valid & out_ready  -> main <= in_data, stay ONE
//           in_valid & !out_ready -> skid <= in_data, TWO
//           !in_valid & out_ready -> main <= bubble, EMPTY
//           neither               -> hold
//     TWO:  out_ready -> main <= skid, skid <= bubble, ONE; else hold. in_data ignored.
//   SKID = 0: one entry; in_ready = !out_valid | out_ready (combinational).
//     Accepted input loads main and sets valid. Output consumed with no input clears
//     valid and loads bubble. Simultaneous in/out transfer loads the new word.
//   Ordering: strictly FIFO; no entry is ever duplicated or lost except by flush or reset.
//   Held data is stable while out_valid & !out_ready.
//   in_data while in_ready = 0 must not affect state.
// TESTING
//   1 Reset: drive reset = 0 mid-stream with state TWO -> out_valid = 0, out_data lane0 = NOP_IR,
//     other lanes 0; after release in_ready = 1.
//   2 Streaming: out_ready = 1; feed 8 words lane0 = 0x100+i every cycle -> out_data lane0
//     = 0x100+i one cycle later, 8 consecutive valid cycles, in_ready never drops.
//   3 Backpressure (SKID = 1): out_ready = 0; push A, B, C -> A and B accepted, in_ready = 0
//     after B, C held upstream; release out_ready -> out order A, B, C.
//   4 Flush: state TWO holding A, B; pulse flush with in_valid = 1 (word D) -> next cycle
//     out_valid = 0, lane0 = NOP_IR, D not captured, in_ready = 1.
//   5 SKID = 0: out_ready = 0 with one entry -> in_ready = 0; set out_ready = 1 with in_valid
//     -> in_ready = 1 same cycle, new word replaces old.
//   6 Widths: WIDTH = 8, LANES = 5 -> random valid/ready scoreboard of 1000 words;
//     every lane matches in order.

Source files
------------

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline register: LANES x WIDTH words behind a valid/ready handshake,
// with an optional 2-entry skid buffer and a synchronous flush that empties the stage.
module pipe_stage_latch #(
  parameter int                WIDTH  = 32,
  parameter int                LANES  = 3,
  parameter int                SKID   = 1,
  parameter logic [WIDTH-1:0]  NOP_IR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data
);

  localparam int DW = LANES * WIDTH;
  // Lane 0 carries the NOP instruction, every other lane bubbles to zero.
  localparam logic [DW-1:0] BUBBLE = DW'(NOP_IR);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  generate
    if (SKID != 0) begin : g_skid
      state_t        r_state;
      logic [DW-1:0] r_main;
      logic [DW-1:0] r_skid;
      logic          r_valid;
      logic          r_ready;

      // in_ready is a register so upstream never sees a path from out_ready.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_state <= S_EMPTY;
          r_main  <= BUBBLE;
          r_skid  <= BUBBLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end else if (flush) begin
          r_state <= S_EMPTY;
          r_main  <= BUBBLE;
          r_skid  <= BUBBLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end else begin
          case (r_state)
            S_EMPTY: begin
              if (in_valid) begin
                r_main  <= in_data;
                r_state <= S_ONE;
                r_valid <= 1'b1;
              end
            end
            S_ONE: begin
              if (in_valid && out_ready) begin
                r_main <= in_data;
              end else if (in_valid) begin
                r_skid  <= in_data;
                r_state <= S_TWO;
                r_ready <= 1'b0;
              end else if (out_ready) begin
                r_main  <= BUBBLE;
                r_state <= S_EMPTY;
                r_valid <= 1'b0;
              end
            end
            S_TWO: begin
              if (out_ready) begin
                r_main  <= r_skid;
                r_skid  <= BUBBLE;
                r_state <= S_ONE;
                r_ready <= 1'b1;
              end
            end
            default: begin
              r_state <= S_EMPTY;
              r_main  <= BUBBLE;
              r_skid  <= BUBBLE;
              r_valid <= 1'b0;
              r_ready <= 1'b1;
            end
          endcase
        end
      end

      assign in_ready  = r_ready;
      assign out_valid = r_valid;
      assign out_data  = r_main;
    end else begin : g_single
      logic [DW-1:0] r_main;
      logic          r_valid;
      logic          w_in_ready;

      // A full stage still accepts when the head leaves this very cycle.
      assign w_in_ready = !r_valid || out_ready;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_main  <= BUBBLE;
          r_valid <= 1'b0;
        end else if (flush) begin
          r_main  <= BUBBLE;
          r_valid <= 1'b0;
        end else if (in_valid && w_in_ready) begin
          r_main  <= in_data;
          r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
          r_main  <= BUBBLE;
          r_valid <= 1'b0;
        end
      end

      assign in_ready  = w_in_ready;
      assign out_valid = r_valid;
      assign out_data  = r_main;
    end
  endgenerate

endmodule
